// File: rtl/cbus_width_splitter_if.sv
// Wide-side request/response and narrow CBUS signals of the width splitter.
// slave: the splitter itself; master: the agent driving both sides.
interface cbus_width_splitter_if #(
   parameter int DW = 64,
   parameter int AW = 32
);
   logic          wide_req;
   logic          wide_cmd;
   logic [AW-1:0] wide_addr;
   logic [DW-1:0] wide_wrdata;
   logic          wide_waccept;
   logic          wide_rresp;
   logic [DW-1:0] wide_rddata;
   logic          cbus_req;
   logic          cbus_cmd;
   logic [AW+1:0] cbus_addr;
   logic [31:0]   cbus_wrdata;
   logic          cbus_waccept;
   logic          cbus_rresp;
   logic [31:0]   cbus_rddata;
   logic          err;

   modport slave (
      input  wide_req,
      input  wide_cmd,
      input  wide_addr,
      input  wide_wrdata,
      output wide_waccept,
      output wide_rresp,
      output wide_rddata,
      output cbus_req,
      output cbus_cmd,
      output cbus_addr,
      output cbus_wrdata,
      input  cbus_waccept,
      input  cbus_rresp,
      input  cbus_rddata,
      output err
   );

   modport master (
      output wide_req,
      output wide_cmd,
      output wide_addr,
      output wide_wrdata,
      input  wide_waccept,
      input  wide_rresp,
      input  wide_rddata,
      input  cbus_req,
      input  cbus_cmd,
      input  cbus_addr,
      input  cbus_wrdata,
      output cbus_waccept,
      output cbus_rresp,
      output cbus_rddata,
      input  err
   );
endinterface

// File: rtl/cbus_width_splitter.sv
// Splits one DW-bit wide transaction into NW back-to-back 32-bit CBUS beats.
// Optional stall timeout: define CBUS_WIDTH_SPLITTER_TIMEOUT_EN.
module cbus_width_splitter #(
   parameter int DW = 64,
   parameter int AW = 32
) (
   input logic                  clk,
   input logic                  sreset_n,
   cbus_width_splitter_if.slave bus
);
   localparam int NW = DW / 32;
   localparam logic [1:0] LAST_PH = 2'(NW - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_XFER = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [1:0]    phase_q, phase_d;
   logic          cmd_q, cmd_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          wacc_q, wacc_d;
   logic          rresp_q, rresp_d;
   logic          hs;
   logic          last;
   logic          stall_to;
   logic [31:0]   wr_word;

   // only the strobe matching the captured command completes a beat
   assign hs = (state_q == S_XFER) &
               (cmd_q ? bus.cbus_rresp : bus.cbus_waccept);
   assign last = (phase_q == LAST_PH);

   always_comb begin
      wr_word = 32'd0;
      for (int w = 0; w < NW; w++) begin
         if (phase_q == 2'(w)) wr_word = wdata_q[w*32 +: 32];
      end
   end

`ifdef CBUS_WIDTH_SPLITTER_TIMEOUT_EN
   logic [7:0] cnt_q, cnt_d;
   logic       err_q;

   always_comb begin
      cnt_d = 8'd0;
      if ((state_q == S_XFER) && !hs && (cnt_q != 8'hFF))
         cnt_d = cnt_q + 8'd1;
   end

   assign stall_to = (state_q == S_XFER) & ~hs & (cnt_q == 8'hFF);

   always_ff @(posedge clk) begin
      if (!sreset_n) begin
         cnt_q <= 8'd0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= stall_to;
      end
   end

   assign bus.err = err_q;
`else
   assign stall_to = 1'b0;
   assign bus.err  = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      cmd_d   = cmd_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      wacc_d  = 1'b0;
      rresp_d = 1'b0;
      unique case (1'b1)
         (state_q == S_IDLE): begin
            if (bus.wide_req) begin
               cmd_d   = bus.wide_cmd;
               addr_d  = bus.wide_addr;
               wdata_d = bus.wide_wrdata;
               phase_d = 2'd0;
               state_d = S_XFER;
            end
         end
         (state_q == S_XFER): begin
            if (hs) begin
               if (cmd_q) begin
                  for (int w = 0; w < NW; w++) begin
                     if (phase_q == 2'(w))
                        rdata_d[w*32 +: 32] = bus.cbus_rddata;
                  end
               end
               if (last) begin
                  state_d = S_RESP;
                  wacc_d  = ~cmd_q;
                  rresp_d = cmd_q;
               end else begin
                  phase_d = phase_q + 2'd1;
               end
            end else if (stall_to) begin
               state_d = S_RESP;
               wacc_d  = ~cmd_q;
               rresp_d = cmd_q;
            end
         end
         (state_q == S_RESP): begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!sreset_n) begin
         state_q <= S_IDLE;
         phase_q <= 2'd0;
         cmd_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         wacc_q  <= 1'b0;
         rresp_q <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         cmd_q   <= cmd_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         wacc_q  <= wacc_d;
         rresp_q <= rresp_d;
      end
   end

   assign bus.cbus_req     = (state_q == S_XFER);
   assign bus.cbus_cmd     = cmd_q;
   assign bus.cbus_addr    = {addr_q, phase_q};
   assign bus.cbus_wrdata  = wr_word;
   assign bus.wide_waccept = wacc_q;
   assign bus.wide_rresp   = rresp_q;
   assign bus.wide_rddata  = rdata_q;
endmodule

// File: tb/tb_cbus_width_splitter.sv
// Bench for cbus_width_splitter: DW=64 and DW=96 instances against a
// word-addressed memory model of the narrow CBUS target.
module tb_cbus_width_splitter;
   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          sreset_n = 1'b0;
   logic          sel = 1'b0;
   logic          wreq = 1'b0;
   logic          wcmd = 1'b0;
   logic [AW-1:0] waddr = '0;
   logic [95:0]   wdata = '0;
   logic          cb_wacc = 1'b0;
   logic          cb_rresp = 1'b0;
   logic [31:0]   cb_rdata = '0;

   int checks = 0;
   int errors = 0;
   logic [95:0] last_rd [2];
   logic [31:0] mem [logic [AW+1:0]];

   always #5 clk = ~clk;

   cbus_width_splitter_if #(.DW(64), .AW(AW)) b64 ();
   cbus_width_splitter_if #(.DW(96), .AW(AW)) b96 ();

   cbus_width_splitter #(.DW(64), .AW(AW)) u64 (
      .clk(clk), .sreset_n(sreset_n), .bus(b64.slave));
   cbus_width_splitter #(.DW(96), .AW(AW)) u96 (
      .clk(clk), .sreset_n(sreset_n), .bus(b96.slave));

   assign b64.wide_req     = wreq & ~sel;
   assign b64.wide_cmd     = wcmd;
   assign b64.wide_addr    = waddr;
   assign b64.wide_wrdata  = wdata[63:0];
   assign b64.cbus_waccept = cb_wacc;
   assign b64.cbus_rresp   = cb_rresp;
   assign b64.cbus_rddata  = cb_rdata;
   assign b96.wide_req     = wreq & sel;
   assign b96.wide_cmd     = wcmd;
   assign b96.wide_addr    = waddr;
   assign b96.wide_wrdata  = wdata;
   assign b96.cbus_waccept = cb_wacc;
   assign b96.cbus_rresp   = cb_rresp;
   assign b96.cbus_rddata  = cb_rdata;

   logic          c_req, c_cmd, w_acc, w_rr, e;
   logic [AW+1:0] c_addr;
   logic [31:0]   c_wd;
   logic [95:0]   w_rd;

   assign c_req  = sel ? b96.cbus_req : b64.cbus_req;
   assign c_cmd  = sel ? b96.cbus_cmd : b64.cbus_cmd;
   assign c_addr = sel ? b96.cbus_addr : b64.cbus_addr;
   assign c_wd   = sel ? b96.cbus_wrdata : b64.cbus_wrdata;
   assign w_acc  = sel ? b96.wide_waccept : b64.wide_waccept;
   assign w_rr   = sel ? b96.wide_rresp : b64.wide_rresp;
   assign e      = sel ? b96.err : b64.err;
   assign w_rd   = sel ? b96.wide_rddata : {32'd0, b64.wide_rddata};

   task automatic chk(input string tag,
                      input logic [127:0] obs,
                      input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One wide transaction; the target model stalls randomly
   // (stall_pct) plus nstall0 forced stalls on the first beat.
   task automatic do_txn(input bit s, input bit rd,
                         input logic [AW-1:0] a,
                         input logic [95:0] d,
                         input int stall_pct,
                         input int nstall0);
      int nw;
      int ph;
      int stalls;
      int cyc;
      bit done;
      logic [95:0] exp_rd;
      logic [AW+1:0] key;
      nw = s ? 3 : 2;
      ph = 0;
      stalls = 0;
      cyc = 0;
      done = 0;
      exp_rd = '0;
      sel = s;
      wcmd = rd;
      waddr = a;
      wdata = d;
      wreq = 1'b1;
      while (!done) begin
         @(posedge clk);
         #1;
         cyc++;
         cb_wacc = 1'b0;
         cb_rresp = 1'b0;
         if (w_acc || w_rr) begin
            done = 1;
            chk("resp_kind", {w_rr, w_acc}, rd ? 2'b10 : 2'b01);
            chk("latency", cyc, nw + 1 + stalls);
            chk("req_low_in_resp", c_req, 1'b0);
            chk("err_low", e, 1'b0);
            if (rd) last_rd[int'(s)] = exp_rd;
            chk("rddata", w_rd, last_rd[int'(s)]);
         end else if (cyc > 400) begin
            done = 1;
            chk("resp_timeout", cyc, nw + 1 + stalls);
         end else if (!c_req) begin
            chk("req_high_in_xfer", c_req, 1'b1);
         end else begin
            chk("cmd", c_cmd, rd);
            chk("addr", c_addr, {a, 2'(ph)});
            if (!rd) chk("wrdata", c_wd, d[ph*32 +: 32]);
            if ((ph == 0 && stalls < nstall0) ||
                ($urandom_range(99) < stall_pct)) begin
               stalls++;
               if ($urandom_range(1) == 1 && nstall0 == 0) begin
                  if (rd) cb_wacc = 1'b1;
                  else cb_rresp = 1'b1;
               end
            end else begin
               key = {a, 2'(ph)};
               if (rd) begin
                  cb_rdata = mem.exists(key) ? mem[key] : $urandom;
                  exp_rd[ph*32 +: 32] = cb_rdata;
                  cb_rresp = 1'b1;
               end else begin
                  mem[key] = d[ph*32 +: 32];
                  cb_wacc = 1'b1;
               end
               ph++;
            end
         end
      end
      // wide_req still high through RESP: must not restart
      @(posedge clk);
      #1;
      cb_wacc = 1'b0;
      cb_rresp = 1'b0;
      chk("pulse_one_cycle", {w_rr, w_acc}, 2'b00);
      chk("no_restart", c_req, 1'b0);
      chk("rddata_hold", w_rd, last_rd[int'(s)]);
      wreq = 1'b0;
   endtask

   initial begin
      int quiet;
      int bad;
      int cyc;
      logic [95:0] rd_a;
      last_rd[0] = '0;
      last_rd[1] = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_req64", b64.cbus_req, 1'b0);
      chk("rst_cmd64", b64.cbus_cmd, 1'b0);
      chk("rst_addr64", b64.cbus_addr, 0);
      chk("rst_wd64", b64.cbus_wrdata, 0);
      chk("rst_wacc64", b64.wide_waccept, 1'b0);
      chk("rst_rresp64", b64.wide_rresp, 1'b0);
      chk("rst_rd64", b64.wide_rddata, 0);
      chk("rst_err64", b64.err, 1'b0);
      chk("rst_req96", b96.cbus_req, 1'b0);
      chk("rst_addr96", b96.cbus_addr, 0);
      chk("rst_rd96", b96.wide_rddata, 0);
      chk("rst_err96", b96.err, 1'b0);
      @(negedge clk);
      sreset_n = 1'b1;

      // DW=64 write, no stalls
      do_txn(1'b0, 1'b0, 32'h10, 96'h0_11223344_55667788, 0, 0);

      // DW=64 read, one stall on phase 0
      mem[{32'h10, 2'd0}] = 32'hAAAA0000;
      mem[{32'h10, 2'd1}] = 32'hBBBB1111;
      do_txn(1'b0, 1'b1, 32'h10, '0, 0, 1);
      rd_a = 96'h0_BBBB1111_AAAA0000;
      chk("read_assembled", w_rd, rd_a);

      // DW=96 write, back-to-back beats
      do_txn(1'b1, 1'b0, 32'h20, 96'h000000CC_000000BB_000000AA, 0, 0);
      do_txn(1'b1, 1'b1, 32'h20, '0, 0, 0);
      rd_a = 96'h000000CC_000000BB_000000AA;
      chk("read96_back", w_rd, rd_a);

      for (int i = 0; i < 40; i++) begin
         do_txn(1'($urandom_range(1)), 1'($urandom_range(1)),
                AW'($urandom_range(7)),
                {$urandom, $urandom, $urandom}, 30, 0);
      end

      // reset during phase 1 of a read
      sel = 1'b0;
      wcmd = 1'b1;
      waddr = 32'h5;
      wreq = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_ph0_req", c_req, 1'b1);
      cb_rdata = 32'h12345678;
      cb_rresp = 1'b1;
      @(posedge clk);
      #1;
      cb_rresp = 1'b0;
      chk("rst_ph1_addr", c_addr, {32'h5, 2'd1});
      sreset_n = 1'b0;
      wreq = 1'b0;
      @(posedge clk);
      #1;
      sreset_n = 1'b1;
      chk("rst_req_drop", c_req, 1'b0);
      chk("rst_no_rresp", w_rr, 1'b0);
      chk("rst_rddata", w_rd, 0);
      last_rd[0] = '0;
      last_rd[1] = '0;
      quiet = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (w_rr || c_req) quiet++;
      end
      chk("rst_quiet", quiet, 0);
      do_txn(1'b0, 1'b1, 32'h5, '0, 0, 0);

      // target never accepts a write
      sel = 1'b0;
      wcmd = 1'b0;
      waddr = 32'h3;
      wreq = 1'b1;
      cb_wacc = 1'b0;
      cb_rresp = 1'b0;
`ifdef CBUS_WIDTH_SPLITTER_TIMEOUT_EN
      cyc = 0;
      while (!w_acc && cyc < 300) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      // entry cycle + 255 stall increments, abort one cycle later
      chk("timeout_latency", cyc, 2 + 255);
      chk("timeout_err", e, 1'b1);
      chk("timeout_req_low", c_req, 1'b0);
      wreq = 1'b0;
      @(posedge clk);
      #1;
      chk("timeout_err_pulse", e, 1'b0);
`else
      bad = 0;
      repeat (1000) begin
         @(posedge clk);
         #1;
         if (c_req !== 1'b1 || e !== 1'b0 || w_acc !== 1'b0) bad++;
      end
      chk("stuck_xfer", bad, 0);
      chk("no_err", e, 1'b0);
      wreq = 1'b0;
`endif
      sreset_n = 1'b0;
      @(posedge clk);
      #1;
      sreset_n = 1'b1;
      chk("final_idle", c_req, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cbus_width_splitter.md
CBUS_WIDTH_SPLITTER -- requirements
Module: cbus_width_splitter

Interface
REQ-001 SHALL have parameter DW, default 64, meaning wide data width; legal values 64 and 96 only; NW = DW/32 words.
REQ-002 SHALL have parameter AW, default 32, meaning wide word address width.
REQ-003 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port sreset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port wide_req  input  1  wide transaction request, held until its response.
REQ-006 SHALL have port wide_cmd  input  1  1 = read, 0 = write.
REQ-007 SHALL have port wide_addr  input  AW  wide word address.
REQ-008 SHALL have port wide_wrdata  input  DW  write data, word 0 in [31:0].
REQ-009 SHALL have port wide_waccept  output  1  one-cycle write-complete pulse.
REQ-010 SHALL have port wide_rresp  output  1  one-cycle read-response pulse.
REQ-011 SHALL have port wide_rddata  output  DW  assembled read data, valid with wide_rresp.
REQ-012 SHALL have port cbus_req / cbus_cmd  output  1 / 1  narrow CBUS request and command.
REQ-013 SHALL have port cbus_addr  output  AW+2  {captured wide_addr, 2-bit phase index}.
REQ-014 SHALL have port cbus_wrdata  output  32  current write word.
REQ-015 SHALL have port cbus_waccept / cbus_rresp  input  1 / 1  narrow write accept / read response.
REQ-016 SHALL have port cbus_rddata  input  32  narrow read data, valid with cbus_rresp.
REQ-017 SHALL have port err  output  1  timeout error pulse (see Configuration).

Function
REQ-018 SHALL implement FSM states IDLE, XFER, RESP.
REQ-019 In IDLE with wide_req=1, SHALL capture wide_cmd, wide_addr, wide_wrdata, clear phase to 0, go to XFER.
REQ-020 In XFER, SHALL drive cbus_req=1, cbus_cmd=captured cmd, cbus_addr={addr,phase}, cbus_wrdata=captured word[phase], all from registers.
REQ-021 Handshake: write completes on cbus_waccept=1, read on cbus_rresp=1, same cycle as cbus_req=1; non-matching strobe SHALL be ignored.
REQ-022 On read handshake, SHALL store cbus_rddata into wide_rddata word[phase].
REQ-023 On handshake with phase<NW-1, SHALL increment phase and stay in XFER (cbus_req stays high: back-to-back).
REQ-024 On handshake with phase=NW-1, SHALL go to RESP; cbus_req low in RESP.
REQ-025 In RESP, SHALL pulse wide_waccept (write) or wide_rresp (read) for exactly one cycle, then go to IDLE.
REQ-026 Minimum latency, wide_req sampled to response pulse: NW+1 cycles; each narrow stall adds one cycle.
REQ-027 wide_req observed in RESP SHALL be ignored; a new transaction is accepted only from IDLE (one idle cycle minimum between transactions).
REQ-028 wide_rddata SHALL hold its value outside RESP until overwritten by a later read.
REQ-029 Phase counter SHALL never exceed NW-1; no wrap beyond NW words.

Reset
REQ-030 On sreset_n=0 at a clock edge, SHALL enter IDLE, phase=0, regardless of current state, including mid-XFER.
REQ-031 Reset values: cbus_req=0, cbus_cmd=0, cbus_addr=0, cbus_wrdata=0, wide_waccept=0, wide_rresp=0, wide_rddata=0, err=0.
REQ-032 A transaction interrupted by reset SHALL produce no response pulse.

Configuration
REQ-033 Macro CBUS_WIDTH_SPLITTER_TIMEOUT_EN, when defined: 8-bit stall counter, cleared on each handshake and on XFER entry, incremented per XFER cycle without handshake.
REQ-034 With macro, counter reaching 255 SHALL abort: cbus_req low next cycle, err pulsed one cycle together with the wide_waccept/wide_rresp pulse, FSM back to IDLE.
REQ-035 Without macro, no counter is built, err is tied 0, XFER waits indefinitely.

Verification
REQ-036 DW=64, write addr 0x10, data 0x11223344_55667788, waccept always 1 -> cbus words 0x55667788 @addr 0x40, 0x11223344 @0x41; wide_waccept 3 cycles after req.
REQ-037 DW=64, read addr 0x10, cbus_rresp 1 cycle late on phase 0, rddata 0xAAAA0000 then 0xBBBB1111 -> wide_rddata 0xBBBB1111_AAAA0000, wide_rresp 4 cycles after req.
REQ-038 DW=96, write 0xCC_BB_AA words -> three back-to-back cbus writes, phases 0,1,2, addr low bits 00,01,10, response at cycle 4.
REQ-039 sreset_n low during phase 1 of a read -> cbus_req 0 next cycle, no wide_rresp, next read completes normally.
REQ-040 With CBUS_WIDTH_SPLITTER_TIMEOUT_EN, cbus_waccept held 0 -> err and wide_waccept pulse together after 255 stall cycles; without macro, cbus_req stays high 1000 cycles, err stays 0.
